// File: rtl/rbus_pkg.sv
// rbus_pkg: ring control field layout, packet lengths and node FSM states
package rbus_pkg;
  localparam int REQ_V = 11;
  localparam int REQ_LONG = 10;
  localparam int PRIO_HI = 9;
  localparam int PRIO_LO = 8;
  localparam int ID_HI = 7;
  localparam int ID_LO = 0;
  localparam logic [3:0] SHORT_LEN = 4'd2;
  localparam logic [3:0] LONG_LEN = 4'd9;
  typedef enum logic [1:0] {LOAD, REQ, WAIT, SEND} state_t;
  function automatic logic [11:0] mk_ctrl(input logic lng, input logic [1:0] prio, input logic [7:0] id);
    return {1'b1, lng, prio, id};
  endfunction
endpackage

// File: rtl/rbus_d2r_pkt_buf.sv
// rbus_d2r_pkt_buf: 9x72 sequential packet buffer with length checks
module rbus_d2r_pkt_buf
  import rbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [71:0] wr_data,
  input  logic        rd_en,
  input  logic        flush,
  input  logic        lng,
  output logic [71:0] rd_data,
  output logic [3:0]  wr_cnt,
  output logic        last_ok,
  output logic        wr_full,
  output logic        rd_last
);
  logic [71:0] mem [LONG_LEN];
  logic [3:0]  rd_cnt;
  logic [3:0]  len;
  assign len = lng ? LONG_LEN : SHORT_LEN;
  assign rd_data = mem[rd_cnt];
  // counts are compared before the current word/read is taken
  assign last_ok = wr_cnt == len - 4'd1;
  assign wr_full = wr_cnt == LONG_LEN - 4'd1;
  assign rd_last = rd_cnt == len - 4'd1;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_cnt] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (flush) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_en) wr_cnt <= wr_cnt + 4'd1;
      if (rd_en) rd_cnt <= rd_cnt + 4'd1;
    end
endmodule

// File: rtl/rbus_d2r_node.sv
// rbus_d2r_node: device-side ring injector that requests, waits for a grant and overwrites the slot
module rbus_d2r_node
  import rbus_pkg::*;
#(
  parameter logic [7:0] NODE_ID = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sof,
  input  logic [11:0] i_ctrl,
  input  logic [71:0] i_data,
  output logic        o_sof,
  output logic [11:0] o_ctrl,
  output logic [71:0] o_data,
  input  logic        dev_valid,
  input  logic [71:0] dev_data,
  input  logic        dev_last,
  input  logic        dev_long,
  input  logic [1:0]  dev_prio,
  output logic        dev_ready,
  output logic        o_err
);
  state_t      state, state_n;
  logic        pkt_long;
  logic [1:0]  pkt_prio;
  logic        acc, rd_en, flush, err_n;
  logic        last_ok, wr_full, rd_last;
  logic [3:0]  wr_cnt;
  logic [71:0] rd_data, data_n;
  logic [11:0] ctrl_n, own_req;
  logic        free_slot, grant_hit, req_back;
  assign dev_ready = (state == LOAD) && !rst;
  assign acc = dev_valid && dev_ready;
  assign own_req = mk_ctrl(pkt_long, pkt_prio, NODE_ID);
  assign free_slot = !i_sof && !i_ctrl[REQ_V];
  assign grant_hit = i_sof && i_ctrl[REQ_V] && i_ctrl[ID_HI:ID_LO] == NODE_ID && i_ctrl[REQ_LONG] == pkt_long;
  // only this node issues requests with its id, so valid+id identifies our own
  assign req_back = !i_sof && i_ctrl[REQ_V] && i_ctrl[ID_HI:ID_LO] == NODE_ID;
  rbus_d2r_pkt_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (acc),
    .wr_data (dev_data),
    .rd_en   (rd_en),
    .flush   (flush),
    .lng     (pkt_long),
    .rd_data (rd_data),
    .wr_cnt  (wr_cnt),
    .last_ok (last_ok),
    .wr_full (wr_full),
    .rd_last (rd_last)
  );
  always_comb begin
    state_n = state;
    ctrl_n = i_ctrl;
    data_n = i_data;
    err_n = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    case (state)
      LOAD:
        if (acc) begin
          if (dev_last && last_ok) state_n = REQ;
          else if (dev_last || wr_full) begin
            err_n = 1'b1;
            flush = 1'b1;
          end
        end
      REQ:
        if (free_slot) begin
          ctrl_n = own_req;
          state_n = WAIT;
        end
      WAIT:
        if (grant_hit) begin
          ctrl_n = '0;
          data_n = rd_data;
          rd_en = 1'b1;
          state_n = SEND;
        end else if (req_back) begin
          ctrl_n = '0;
          state_n = REQ;
        end
      SEND:
        if (i_sof) begin
          err_n = 1'b1;
          flush = 1'b1;
          state_n = LOAD;
        end else begin
          data_n = rd_data;
          rd_en = 1'b1;
          flush = rd_last;
          state_n = rd_last ? LOAD : SEND;
        end
      default: state_n = LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LOAD;
      pkt_long <= 1'b0;
      pkt_prio <= '0;
      o_sof <= 1'b0;
      o_ctrl <= '0;
      o_data <= '0;
      o_err <= 1'b0;
    end else begin
      state <= state_n;
      if (acc && wr_cnt == 4'd0) begin
        pkt_long <= dev_long;
        pkt_prio <= dev_prio;
      end
      o_sof <= i_sof;
      o_ctrl <= ctrl_n;
      o_data <= data_n;
      o_err <= err_n;
    end
endmodule

// File: tb/tb_rbus_d2r_node.sv
// tb_rbus_d2r_node: directed checks of request insertion, grant replacement and error paths
module tb_rbus_d2r_node;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_sof = 1'b1;
  logic [11:0] i_ctrl = '0;
  logic [71:0] i_data = '0;
  logic        o_sof;
  logic [11:0] o_ctrl;
  logic [71:0] o_data;
  logic        dev_valid = 1'b0;
  logic [71:0] dev_data = '0;
  logic        dev_last = 1'b0;
  logic        dev_long = 1'b0;
  logic [1:0]  dev_prio = '0;
  logic        dev_ready;
  logic        o_err;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  rbus_d2r_node #(.NODE_ID(8'h05)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_sof     (i_sof),
    .i_ctrl    (i_ctrl),
    .i_data    (i_data),
    .o_sof     (o_sof),
    .o_ctrl    (o_ctrl),
    .o_data    (o_data),
    .dev_valid (dev_valid),
    .dev_data  (dev_data),
    .dev_last  (dev_last),
    .dev_long  (dev_long),
    .dev_prio  (dev_prio),
    .dev_ready (dev_ready),
    .o_err     (o_err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ring(input logic s, input logic [11:0] c, input logic [71:0] d);
    i_sof = s;
    i_ctrl = c;
    i_data = d;
  endtask
  task automatic load_pkt(input int n, input logic lng, input logic [1:0] pr, input logic [71:0] base, input int last_at);
    for (int i = 0; i < n; i++) begin
      dev_valid = 1'b1;
      dev_data = base + 72'(i);
      dev_long = lng;
      dev_prio = pr;
      dev_last = (i == last_at - 1);
      tick();
    end
    dev_valid = 1'b0;
    dev_last = 1'b0;
  endtask
  task automatic test_reset;
    #2;
    tests++;
    if ({o_sof, o_ctrl, o_data, dev_ready, o_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs sof=%b ctrl=%h data=%h ready=%b err=%b exp all 0", o_sof, o_ctrl, o_data, dev_ready, o_err);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (dev_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready got=%b exp=1", dev_ready);
    end
  endtask
  task automatic test_short;
    ring(1'b0, 12'h000, 72'h11);
    load_pkt(2, 1'b0, 2'd2, 72'h100, 2);
    tests++;
    if (o_ctrl !== 12'h000 || dev_ready !== 1'b0) begin
      fails++;
      $display("FAIL short_no_insert_on_last ctrl=%h ready=%b exp ctrl=000 ready=0", o_ctrl, dev_ready);
    end
    ring(1'b0, 12'h000, 72'h55);
    tick();
    tests++;
    if (o_ctrl !== 12'hA05 || o_data !== 72'h55 || o_sof !== 1'b0) begin
      fails++;
      $display("FAIL short_request ctrl=%h data=%h sof=%b exp ctrl=a05 data=55 sof=0", o_ctrl, o_data, o_sof);
    end
    ring(1'b0, 12'h907, 72'h66);
    tick();
    tests++;
    if (o_ctrl !== 12'h907 || o_data !== 72'h66) begin
      fails++;
      $display("FAIL short_other_req ctrl=%h data=%h exp ctrl=907 data=66", o_ctrl, o_data);
    end
    ring(1'b1, 12'hA05, 72'h77);
    tick();
    tests++;
    if (o_sof !== 1'b1 || o_ctrl !== 12'h000 || o_data !== 72'h100) begin
      fails++;
      $display("FAIL short_grant_header sof=%b ctrl=%h data=%h exp sof=1 ctrl=000 data=100", o_sof, o_ctrl, o_data);
    end
    ring(1'b0, 12'h803, 72'h88);
    tick();
    tests++;
    if (o_data !== 72'h101 || o_ctrl !== 12'h803 || dev_ready !== 1'b1) begin
      fails++;
      $display("FAIL short_payload data=%h ctrl=%h ready=%b exp data=101 ctrl=803 ready=1", o_data, o_ctrl, dev_ready);
    end
    ring(1'b1, 12'h000, 72'h0);
  endtask
  task automatic test_long_class;
    logic [71:0] ed;
    logic [11:0] ec;
    load_pkt(9, 1'b1, 2'd0, 72'h200, 9);
    tests++;
    if (dev_ready !== 1'b0) begin
      fails++;
      $display("FAIL long_ready_drop got=%b exp=0", dev_ready);
    end
    ring(1'b0, 12'h000, 72'h1);
    tick();
    tests++;
    if (o_ctrl !== 12'hC05) begin
      fails++;
      $display("FAIL long_request ctrl=%h exp=c05", o_ctrl);
    end
    ring(1'b1, 12'h805, 72'hABC);
    tick();
    tests++;
    if (o_ctrl !== 12'h805 || o_data !== 72'hABC) begin
      fails++;
      $display("FAIL long_wrong_class ctrl=%h data=%h exp ctrl=805 data=abc", o_ctrl, o_data);
    end
    ring(1'b1, 12'hC05, 72'h5);
    tick();
    tests++;
    if (o_ctrl !== 12'h000 || o_data !== 72'h200) begin
      fails++;
      $display("FAIL long_grant_header ctrl=%h data=%h exp ctrl=000 data=200", o_ctrl, o_data);
    end
    for (int k = 1; k <= 8; k++) begin
      ec = 12'h900 + 12'(k);
      ed = 72'h200 + 72'(k);
      ring(1'b0, ec, 72'hF0);
      tick();
      tests++;
      if (o_data !== ed || o_ctrl !== ec) begin
        fails++;
        $display("FAIL long_payload_%0d data=%h ctrl=%h exp data=%h ctrl=%h", k, o_data, o_ctrl, ed, ec);
      end
    end
    tests++;
    if (dev_ready !== 1'b1) begin
      fails++;
      $display("FAIL long_back_to_load ready=%b exp=1", dev_ready);
    end
    ring(1'b1, 12'h000, 72'h0);
  endtask
  task automatic test_req_return;
    load_pkt(9, 1'b1, 2'd0, 72'h400, 9);
    ring(1'b0, 12'h000, 72'h1);
    tick();
    tests++;
    if (o_ctrl !== 12'hC05) begin
      fails++;
      $display("FAIL ret_request ctrl=%h exp=c05", o_ctrl);
    end
    ring(1'b0, 12'hC05, 72'h2);
    tick();
    tests++;
    if (o_ctrl !== 12'h000 || o_data !== 72'h2) begin
      fails++;
      $display("FAIL ret_cleared ctrl=%h data=%h exp ctrl=000 data=2", o_ctrl, o_data);
    end
    ring(1'b0, 12'h907, 72'h3);
    tick();
    tests++;
    if (o_ctrl !== 12'h907) begin
      fails++;
      $display("FAIL ret_busy_slot ctrl=%h exp=907", o_ctrl);
    end
    ring(1'b0, 12'h000, 72'h4);
    tick();
    tests++;
    if (o_ctrl !== 12'hC05) begin
      fails++;
      $display("FAIL ret_reinsert ctrl=%h exp=c05", o_ctrl);
    end
    ring(1'b1, 12'hC05, 72'h0);
    tick();
    for (int k = 1; k <= 8; k++) begin
      ring(1'b0, 12'h000, 72'h0);
      tick();
    end
    tests++;
    if (o_data !== 72'h408 || dev_ready !== 1'b1) begin
      fails++;
      $display("FAIL ret_send_done data=%h ready=%b exp data=408 ready=1", o_data, dev_ready);
    end
    ring(1'b1, 12'h000, 72'h0);
  endtask
  task automatic test_illegal;
    ring(1'b0, 12'h000, 72'h9);
    load_pkt(4, 1'b0, 2'd1, 72'h500, 4);
    tests++;
    if (o_err !== 1'b1 || dev_ready !== 1'b1) begin
      fails++;
      $display("FAIL illegal_err err=%b ready=%b exp err=1 ready=1", o_err, dev_ready);
    end
    tick();
    tests++;
    if (o_err !== 1'b0 || o_ctrl !== 12'h000) begin
      fails++;
      $display("FAIL illegal_after err=%b ctrl=%h exp err=0 ctrl=000", o_err, o_ctrl);
    end
    tick();
    tests++;
    if (o_ctrl !== 12'h000) begin
      fails++;
      $display("FAIL illegal_no_req ctrl=%h exp=000", o_ctrl);
    end
    load_pkt(2, 1'b0, 2'd3, 72'h600, 2);
    tick();
    tests++;
    if (o_ctrl !== 12'hB05) begin
      fails++;
      $display("FAIL illegal_next_req ctrl=%h exp=b05", o_ctrl);
    end
    ring(1'b1, 12'hB05, 72'h0);
    tick();
    tests++;
    if (o_data !== 72'h600) begin
      fails++;
      $display("FAIL illegal_next_hdr data=%h exp=600", o_data);
    end
    ring(1'b0, 12'h000, 72'h0);
    tick();
    tests++;
    if (o_data !== 72'h601 || dev_ready !== 1'b1) begin
      fails++;
      $display("FAIL illegal_next_pl data=%h ready=%b exp data=601 ready=1", o_data, dev_ready);
    end
    ring(1'b1, 12'h000, 72'h0);
  endtask
  task automatic test_mid_send;
    load_pkt(9, 1'b1, 2'd1, 72'h700, 9);
    ring(1'b0, 12'h000, 72'h1);
    tick();
    tests++;
    if (o_ctrl !== 12'hD05) begin
      fails++;
      $display("FAIL mid_request ctrl=%h exp=d05", o_ctrl);
    end
    ring(1'b1, 12'hD05, 72'h0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      ring(1'b0, 12'h000, 72'h0);
      tick();
    end
    ring(1'b1, 12'h123, 72'hDEAD);
    tick();
    tests++;
    if (o_sof !== 1'b1 || o_ctrl !== 12'h123 || o_data !== 72'hDEAD || o_err !== 1'b1 || dev_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_header sof=%b ctrl=%h data=%h err=%b ready=%b exp 1/123/dead/1/1", o_sof, o_ctrl, o_data, o_err, dev_ready);
    end
    ring(1'b1, 12'h000, 72'h0);
    tick();
    tests++;
    if (o_err !== 1'b0) begin
      fails++;
      $display("FAIL mid_err_pulse err=%b exp=0", o_err);
    end
  endtask
  task automatic test_async_reset;
    load_pkt(2, 1'b0, 2'd2, 72'h800, 2);
    ring(1'b0, 12'h000, 72'hBEEF);
    tick();
    tests++;
    if (o_ctrl !== 12'hA05 || o_data !== 72'hBEEF) begin
      fails++;
      $display("FAIL arst_pre ctrl=%h data=%h exp ctrl=a05 data=beef", o_ctrl, o_data);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({o_sof, o_ctrl, o_data, dev_ready, o_err} !== '0) begin
      fails++;
      $display("FAIL arst_immediate sof=%b ctrl=%h data=%h ready=%b err=%b exp all 0", o_sof, o_ctrl, o_data, dev_ready, o_err);
    end
    ring(1'b0, 12'h000, 72'h1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (dev_ready !== 1'b1 || o_data !== 72'h0) begin
      fails++;
      $display("FAIL arst_release ready=%b data=%h exp ready=1 data=0", dev_ready, o_data);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (o_ctrl !== 12'h000 || o_data !== 72'h1) begin
        fails++;
        $display("FAIL arst_no_stale_req_%0d ctrl=%h data=%h exp ctrl=000 data=1", k, o_ctrl, o_data);
      end
    end
  endtask
  initial begin
    test_reset();
    test_short();
    test_long_class();
    test_req_return();
    test_illegal();
    test_mid_send();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
